// File: rtl/shader_pkg.sv
// Shared shader-pipeline types and default geometry for draw_line, span_fill and the framebuffer.
package shader_pkg;

  localparam int unsigned DEF_H_RES   = 640;
  localparam int unsigned DEF_V_RES   = 480;
  localparam int unsigned DEF_ADDR_W  = 19;
  localparam int unsigned DEF_COLOR_W = 8;
  localparam int unsigned X_W         = 11;
  localparam int unsigned Y_W         = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } span_state_t;

  // Row base y*h_res; callers truncate to their address width (wraps by design).
  function automatic logic [31:0] row_base(input logic [Y_W-1:0] y, input int unsigned h_res);
    return 32'(y) * h_res;
  endfunction

endpackage

// File: rtl/span_fill_if.sv
// Framebuffer write port: valid/ready handshake carrying one pixel address and colour.
interface span_fill_if
  import shader_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned COLOR_W = DEF_COLOR_W
);

  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_ready;

  modport master (output fb_we, output fb_addr, output fb_data, input fb_ready);
  modport slave  (input fb_we, input fb_addr, input fb_data, output fb_ready);

endinterface

// File: rtl/span_setup.sv
// Combinational span normalisation: endpoint swap, row base and (with SPAN_CLIP_EN) clamp/empty detect.
module span_setup
  import shader_pkg::*;
#(
  parameter int unsigned H_RES  = DEF_H_RES,
  parameter int unsigned V_RES  = DEF_V_RES,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic [X_W-1:0]    i_start_x,
  input  logic [X_W-1:0]    i_end_x,
  input  logic [Y_W-1:0]    i_y,
  output logic [X_W-1:0]    o_lo,
  output logic [X_W-1:0]    o_hi,
  output logic [ADDR_W-1:0] o_base,
  output logic              o_empty
);

  logic           w_swap;
  logic [X_W-1:0] w_lo;
  logic [X_W-1:0] w_hi;

  assign w_swap = (i_start_x > i_end_x);
  assign w_lo   = w_swap ? i_end_x   : i_start_x;
  assign w_hi   = w_swap ? i_start_x : i_end_x;
  assign o_lo   = w_lo;
  assign o_base = ADDR_W'(row_base(i_y, H_RES));

`ifdef SPAN_CLIP_EN
  // Clamp the right end to the last column; a span starting off-screen or below the frame is empty.
  assign o_hi    = (32'(w_hi) >= H_RES) ? X_W'(H_RES - 1) : w_hi;
  assign o_empty = (32'(w_lo) >= H_RES) || (32'(i_y) >= V_RES);
`else
  logic w_unused_vres;

  assign w_unused_vres = (V_RES != 0);
  assign o_hi          = w_hi;
  assign o_empty       = 1'b0;
`endif

endmodule

// File: rtl/span_fill.sv
// Horizontal span filler: one framebuffer write per pixel, span_done pulse when finished.
// Optional clipping to the visible frame is compiled in with SPAN_CLIP_EN.
module span_fill
  import shader_pkg::*;
#(
  parameter int unsigned H_RES   = DEF_H_RES,
  parameter int unsigned V_RES   = DEF_V_RES,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               draw,
  input  logic [X_W-1:0]     start_x,
  input  logic [X_W-1:0]     end_x,
  input  logic [Y_W-1:0]     y_coord,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               span_done,
  span_fill_if.master        fb
);

  span_state_t        r_state;
  logic [X_W-1:0]     r_start;
  logic [X_W-1:0]     r_end;
  logic [Y_W-1:0]     r_y;
  logic [X_W-1:0]     r_x;
  logic [X_W-1:0]     r_hi;
  logic [ADDR_W-1:0]  r_base;
  logic               r_busy;
  logic               r_done;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_data;

  logic [X_W-1:0]     w_lo;
  logic [X_W-1:0]     w_hi;
  logic [ADDR_W-1:0]  w_base;
  logic               w_empty;
  logic               w_accept;
  logic [X_W-1:0]     w_x_nxt;

  span_setup #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_setup (
    .i_start_x (r_start),
    .i_end_x   (r_end),
    .i_y       (r_y),
    .o_lo      (w_lo),
    .o_hi      (w_hi),
    .o_base    (w_base),
    .o_empty   (w_empty)
  );

  assign w_accept = r_we && fb.fb_ready;
  assign w_x_nxt  = r_x + X_W'(1);

  // Control FSM, x counter and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_start <= '0;
      r_end   <= '0;
      r_y     <= '0;
      r_x     <= '0;
      r_hi    <= '0;
      r_base  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (draw) begin
            r_start <= start_x;
            r_end   <= end_x;
            r_y     <= y_coord;
            r_data  <= color;
            r_busy  <= 1'b1;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_x    <= w_lo;
          r_hi   <= w_hi;
          r_base <= w_base;
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            // First address is built from the unregistered base so FILL starts with it valid.
            r_we    <= 1'b1;
            r_addr  <= w_base + ADDR_W'(w_lo);
            r_state <= FILL;
          end
        end
        FILL: begin
          if (w_accept) begin
            if (r_x == r_hi) begin
              r_we    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_x    <= w_x_nxt;
              r_addr <= r_base + ADDR_W'(w_x_nxt);
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign span_done  = r_done;
  assign fb.fb_we   = r_we;
  assign fb.fb_addr = r_addr;
  assign fb.fb_data = r_data;

endmodule

// File: tb/tb_span_fill.sv
// Directed bench for span_fill; expectations follow SPAN_CLIP_EN when it is defined.
module tb_span_fill;
  import shader_pkg::*;

  localparam int unsigned H_RES   = 640;
  localparam int unsigned V_RES   = 480;
  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned COLOR_W = 8;

  logic               clk;
  logic               reset;
  logic               draw;
  logic [X_W-1:0]     start_x;
  logic [X_W-1:0]     end_x;
  logic [Y_W-1:0]     y_coord;
  logic [COLOR_W-1:0] color;
  logic               busy;
  logic               span_done;

  span_fill_if #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) fb_if ();

  span_fill #(
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .ADDR_W  (ADDR_W),
    .COLOR_W (COLOR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .draw      (draw),
    .start_x   (start_x),
    .end_x     (end_x),
    .y_coord   (y_coord),
    .color     (color),
    .busy      (busy),
    .span_done (span_done),
    .fb        (fb_if)
  );

  int n_tests;
  int n_fail;
  int wr_addr[$];
  int wr_data[$];
  int wr_rel[$];
  int done_rel[$];
  int we_log[0:127];
  int addr_log[0:127];
  int data_log[0:127];
  int busy_log[0:127];
  int done_log[0:127];
  int inj_sx, inj_ex, inj_y, inj_col;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Raise draw for one cycle; caller is aligned just after a rising edge.
  task automatic do_draw(input int sx, input int ex, input int y, input int col);
    wr_addr.delete();
    wr_data.delete();
    wr_rel.delete();
    done_rel.delete();
    start_x = X_W'(sx);
    end_x   = X_W'(ex);
    y_coord = Y_W'(y);
    color   = COLOR_W'(col);
    draw    = 1'b1;
    @(posedge clk);
    #1;
    draw = 1'b0;
  endtask

  // Cycles 1..n after draw: drive ready/reset/extra draws, log outputs at the falling edge.
  task automatic run_span(input int n, input int bp_lo, input int bp_hi,
                          input int inj_a, input int inj_b, input int rst_k);
    for (int k = 1; k <= n; k++) begin
      fb_if.fb_ready = (k >= bp_lo && k <= bp_hi) ? 1'b0 : 1'b1;
      reset          = (k == rst_k);
      draw           = (k == inj_a || k == inj_b);
      if (draw) begin
        start_x = X_W'(inj_sx);
        end_x   = X_W'(inj_ex);
        y_coord = Y_W'(inj_y);
        color   = COLOR_W'(inj_col);
      end
      @(negedge clk);
      we_log[k]   = int'(fb_if.fb_we);
      addr_log[k] = int'(fb_if.fb_addr);
      data_log[k] = int'(fb_if.fb_data);
      busy_log[k] = int'(busy);
      done_log[k] = int'(span_done);
      if (fb_if.fb_we && fb_if.fb_ready) begin
        wr_addr.push_back(int'(fb_if.fb_addr));
        wr_data.push_back(int'(fb_if.fb_data));
        wr_rel.push_back(k);
      end
      if (span_done) done_rel.push_back(k);
      @(posedge clk);
      #1;
    end
    reset          = 1'b0;
    draw           = 1'b0;
    fb_if.fb_ready = 1'b1;
  endtask

  task automatic check_writes(input string tag, input int idx0, input int cnt,
                              input int addr0, input int rel0, input int data);
    for (int i = 0; i < cnt; i++) begin
      if (idx0 + i >= wr_addr.size()) begin
        check_eq({tag, "_count"}, wr_addr.size(), idx0 + cnt);
        break;
      end
      check_eq($sformatf("%s_addr%0d", tag, i), wr_addr[idx0 + i], addr0 + i);
      check_eq($sformatf("%s_cyc%0d", tag, i), wr_rel[idx0 + i], rel0 + i);
      check_eq($sformatf("%s_data%0d", tag, i), wr_data[idx0 + i], data);
    end
  endtask

  task automatic check_done(input string tag, input int exp_n, input int rel);
    check_eq({tag, "_done_n"}, done_rel.size(), exp_n);
    if (exp_n > 0 && done_rel.size() > 0) check_eq({tag, "_done_cyc"}, done_rel[0], rel);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    draw           = 1'b0;
    start_x        = '0;
    end_x          = '0;
    y_coord        = '0;
    color          = '0;
    fb_if.fb_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(span_done), 0);
    check_eq("rst_we", int'(fb_if.fb_we), 0);
    check_eq("rst_addr", int'(fb_if.fb_addr), 0);
    check_eq("rst_data", int'(fb_if.fb_data), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic span y=10, x 5..8
    do_draw(5, 8, 10, 'h3A);
    run_span(8, 0, -1, -1, -1, -1);
    check_eq("basic_count", wr_addr.size(), 4);
    check_writes("basic", 0, 4, 6405, 2, 'h3A);
    check_done("basic", 1, 6);
    for (int k = 1; k <= 8; k++) check_eq($sformatf("basic_busy%0d", k), busy_log[k], (k <= 6) ? 1 : 0);

    // Backpressure on cycles 3-4
    do_draw(5, 8, 10, 'h3A);
    run_span(10, 3, 4, -1, -1, -1);
    check_eq("bp_count", wr_addr.size(), 4);
    check_writes("bp_a", 0, 1, 6405, 2, 'h3A);
    check_writes("bp_b", 1, 3, 6406, 5, 'h3A);
    for (int k = 3; k <= 5; k++) begin
      check_eq($sformatf("bp_hold_we%0d", k), we_log[k], 1);
      check_eq($sformatf("bp_hold_addr%0d", k), addr_log[k], 6406);
    end
    check_done("bp", 1, 8);

    // Single pixel at origin
    do_draw(0, 0, 0, 'h11);
    run_span(5, 0, -1, -1, -1, -1);
    check_eq("single_count", wr_addr.size(), 1);
    check_writes("single", 0, 1, 0, 2, 'h11);
    check_done("single", 1, 3);

    // Reversed endpoints
    do_draw(20, 17, 1, 'h5C);
    run_span(8, 0, -1, -1, -1, -1);
    check_eq("swap_count", wr_addr.size(), 4);
    check_writes("swap", 0, 4, 657, 2, 'h5C);
    check_done("swap", 1, 6);

    // Draw during FILL ignored; draw right after span_done accepted
    inj_sx = 0; inj_ex = 0; inj_y = 2; inj_col = 'hC3;
    do_draw(0, 3, 3, 'h77);
    run_span(12, 0, -1, 3, 7, -1);
    check_eq("busy_count", wr_addr.size(), 5);
    check_writes("busy_a", 0, 4, 1920, 2, 'h77);
    check_writes("busy_b", 4, 1, 1280, 9, 'hC3);
    check_eq("busy_done_n", done_rel.size(), 2);
    if (done_rel.size() == 2) begin
      check_eq("busy_done0", done_rel[0], 6);
      check_eq("busy_done1", done_rel[1], 10);
    end
    check_eq("busy_idle7", busy_log[7], 0);
    check_eq("busy_again8", busy_log[8], 1);

    // Span crossing the right edge
    do_draw(630, 700, 0, 'h42);
    run_span(76, 0, -1, -1, -1, -1);
`ifdef SPAN_CLIP_EN
    check_eq("clip_count", wr_addr.size(), 10);
    check_writes("clip", 0, 10, 630, 2, 'h42);
    check_done("clip", 1, 12);
`else
    check_eq("clip_count", wr_addr.size(), 71);
    check_writes("clip", 0, 71, 630, 2, 'h42);
    check_done("clip", 1, 73);
`endif

    // Span starting off-screen
    do_draw(650, 650, 0, 'h0F);
    run_span(5, 0, -1, -1, -1, -1);
`ifdef SPAN_CLIP_EN
    check_eq("offx_count", wr_addr.size(), 0);
    check_done("offx", 1, 2);
`else
    check_eq("offx_count", wr_addr.size(), 1);
    check_writes("offx", 0, 1, 650, 2, 'h0F);
    check_done("offx", 1, 3);
`endif

    // Max row: address wraps modulo 2^19 when not clipped
    do_draw(0, 0, 65535, 'h99);
    run_span(5, 0, -1, -1, -1, -1);
`ifdef SPAN_CLIP_EN
    check_eq("wrap_count", wr_addr.size(), 0);
    check_done("wrap", 1, 2);
`else
    check_eq("wrap_count", wr_addr.size(), 1);
    check_writes("wrap", 0, 1, 523648, 2, 'h99);
    check_done("wrap", 1, 3);
`endif

    // Reset during FILL
    do_draw(0, 100, 0, 'hAB);
    run_span(8, 0, -1, -1, -1, 5);
    check_eq("mrst_fill_we", we_log[4], 1);
    check_eq("mrst_fill_addr", addr_log[4], 2);
    check_eq("mrst_we", we_log[6], 0);
    check_eq("mrst_busy", busy_log[6], 0);
    check_eq("mrst_done", done_log[6], 0);
    check_eq("mrst_addr", addr_log[6], 0);
    check_eq("mrst_data", data_log[6], 0);
    check_eq("mrst_done_n", done_rel.size(), 0);

    do_draw(2, 3, 0, 'h55);
    run_span(6, 0, -1, -1, -1, -1);
    check_eq("post_count", wr_addr.size(), 2);
    check_writes("post", 0, 2, 2, 2, 'h55);
    check_done("post", 1, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
